mario_pause_ctrl: RTL and testbench

//  Sequences CPU halting for all pause sources: user pause button, OSD-open pause and hiscore RAM access.

---
 rtl/mario_pkg.sv | 23 ++
 rtl/mario_pause_ctrl_if.sv | 28 ++
 rtl/mario_sat_counter.sv | 46 ++++
 rtl/mario_pause_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mario_pause_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mario_pkg.sv
// Shared definitions for the Mario pause controller.
//  - pause_st_t      : pause sequencer states
//  - DIM_CYCLES_48M  : paused cycles before the video is dimmed (10 s at 48 MHz)
//  - ACK_TIMEOUT_DEF : cycles allowed for the Z80 to answer BUSRQ
//  - rise()          : one-cycle rising-edge detect against a registered copy
package mario_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SYNC    = 3'd1,
        HALT    = 3'd2,
        PAUSED  = 3'd3,
        RELEASE = 3'd4
    } pause_st_t;

    localparam logic [31:0] DIM_CYCLES_48M  = 32'd480_000_000;
    localparam logic [15:0] ACK_TIMEOUT_DEF = 16'd4096;

    function automatic logic rise(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/mario_pause_ctrl_if.sv
// Signal bundle between the emu top level (master) and the pause controller (slave).
//  Inputs to the controller : pause button, OSD state, hiscore request, VBLANK, Z80 BUSAK_n
//  Outputs from controller  : Z80 BUSRQ_n, hiscore grant, paused, dim, ack error
interface mario_pause_ctrl_if;

    logic I_PAUSE_BTN;
    logic I_OSD_OPEN;
    logic I_OSD_PAUSE_EN;
    logic I_HS_REQ;
    logic I_VBLANK;
    logic I_CPU_BUSAK_n;
    logic O_CPU_BUSRQ_n;
    logic O_HS_GRANT;
    logic O_PAUSED;
    logic O_DIM;
    logic O_ACK_ERR;

    modport master (
        output I_PAUSE_BTN, I_OSD_OPEN, I_OSD_PAUSE_EN, I_HS_REQ, I_VBLANK, I_CPU_BUSAK_n,
        input  O_CPU_BUSRQ_n, O_HS_GRANT, O_PAUSED, O_DIM, O_ACK_ERR
    );

    modport slave (
        input  I_PAUSE_BTN, I_OSD_OPEN, I_OSD_PAUSE_EN, I_HS_REQ, I_VBLANK, I_CPU_BUSAK_n,
        output O_CPU_BUSRQ_n, O_HS_GRANT, O_PAUSED, O_DIM, O_ACK_ERR
    );

endinterface

// File: rtl/mario_sat_counter.sv
// Saturating up-counter.
//  clk, rst_n : clock, asynchronous active-low reset
//  clr        : synchronous clear (has priority over en)
//  en         : count enable; holds once cnt reaches MAX
//  cnt        : current count (registered)
//  at_max     : cnt == MAX
module mario_sat_counter #(
    parameter int           W   = 32,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, increment below MAX, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/mario_pause_ctrl.sv
// Pause sequencer for the Mario core: merges the pause sources (button toggle,
// OSD pause, hiscore RAM access), halts the Z80 on a VBLANK rising edge via
// BUSRQ_n/BUSAK_n, grants the hiscore engine RAM only while the CPU is held,
// and dims the video after a long user pause.
//  I_CLK_48M, I_RESETn : clock, asynchronous active-low reset
//  bus (slave)         : request inputs, Z80 handshake, status outputs
// All outputs are registered and computed from the next state, so a status
// change appears on the same edge as the state change.
module mario_pause_ctrl
    import mario_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES  = DIM_CYCLES_48M,
    parameter logic [15:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic          I_CLK_48M,
    input  logic          I_RESETn,
    mario_pause_ctrl_if.slave bus
);

    pause_st_t   state_q, state_d;
    logic        btn_prev_q, btn_prev_d;
    logic        vbl_prev_q, vbl_prev_d;
    logic        toggle_q, toggle_d;
    logic        busrq_n_q, busrq_n_d;
    logic        hs_grant_q, hs_grant_d;
    logic        paused_q, paused_d;
    logic        dim_q, dim_d;
    logic        ack_err_q, ack_err_d;

    logic        osd_pause_s;
    logic        want_s;
    logic        vbl_rise_s;
    logic [15:0] ack_cnt_s;
    logic        ack_at_max_s;
    logic        ack_timeout_s;
    logic [31:0] dim_cnt_s;
    logic        dim_at_max_s;
    logic        dim_en_s;
    logic        dim_reach_s;

    assign osd_pause_s = bus.I_OSD_OPEN & bus.I_OSD_PAUSE_EN;
    assign want_s      = toggle_q | osd_pause_s | bus.I_HS_REQ;
    assign vbl_rise_s  = rise(bus.I_VBLANK, vbl_prev_q);

    // Edge-detect history and the button toggle.
    always_comb begin
        btn_prev_d = bus.I_PAUSE_BTN;
        vbl_prev_d = bus.I_VBLANK;
        toggle_d   = toggle_q ^ rise(bus.I_PAUSE_BTN, btn_prev_q);
    end

    // HALT cycle counter; cleared whenever the sequencer is not waiting for BUSAK.
    mario_sat_counter #(.W(16), .MAX(ACK_TIMEOUT)) u_ack_cnt (
        .clk    (I_CLK_48M),
        .rst_n  (I_RESETn),
        .clr    (state_q != HALT),
        .en     (state_q == HALT),
        .cnt    (ack_cnt_s),
        .at_max (ack_at_max_s)
    );

    // Timeout fires on the cycle the count reaches ACK_TIMEOUT, i.e. after
    // exactly ACK_TIMEOUT cycles in HALT; at_max is a backstop.
    assign ack_timeout_s = ack_at_max_s | (ack_cnt_s == (ACK_TIMEOUT - 16'd1));

    // Dim timer only runs for user pauses; a hiscore-only pause never dims.
    assign dim_en_s = (state_q == PAUSED) & (toggle_q | osd_pause_s);

    mario_sat_counter #(.W(32), .MAX(DIM_CYCLES)) u_dim_cnt (
        .clk    (I_CLK_48M),
        .rst_n  (I_RESETn),
        .clr    (state_q != PAUSED),
        .en     (dim_en_s),
        .cnt    (dim_cnt_s),
        .at_max (dim_at_max_s)
    );

    // Dim asserts on the edge where the count becomes DIM_CYCLES.
    assign dim_reach_s = dim_at_max_s | (dim_en_s & (dim_cnt_s == (DIM_CYCLES - 32'd1)));

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ack_err_d = ack_err_q;
        case (state_q)
            RUN: begin
                if (want_s) state_d = SYNC;
                else        state_d = RUN;
            end
            SYNC: begin
                // A request that vanishes before the frame edge never touches the bus.
                if (!want_s)         state_d = RUN;
                else if (vbl_rise_s) state_d = HALT;
                else                 state_d = SYNC;
            end
            HALT: begin
                // Once BUSRQ is out the handshake always completes, even if want drops.
                if (!bus.I_CPU_BUSAK_n) begin
                    state_d = PAUSED;
                end else if (ack_timeout_s) begin
                    state_d   = PAUSED;
                    ack_err_d = 1'b1;
                end else begin
                    state_d = HALT;
                end
            end
            PAUSED: begin
                if (!want_s) state_d = RELEASE;
                else         state_d = PAUSED;
            end
            RELEASE: begin
                // Always return to RUN first so a new request re-aligns to VBLANK.
                if (bus.I_CPU_BUSAK_n) state_d = RUN;
                else                   state_d = RELEASE;
            end
            default: begin
                // Unknown encoding: drop the bus request and resynchronise.
                state_d = RELEASE;
            end
        endcase

        busrq_n_d  = ~((state_d == HALT) | (state_d == PAUSED));
        paused_d   = (state_d == PAUSED);
        // Needs one full PAUSED cycle first: grant trails BUSAK by at least two cycles.
        hs_grant_d = (state_q == PAUSED) & (state_d == PAUSED) & bus.I_HS_REQ;
        dim_d      = (state_d == PAUSED) & dim_reach_s;
    end

    // State, edge history and output registers.
    always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q    <= RUN;
            btn_prev_q <= 1'b0;
            vbl_prev_q <= 1'b0;
            toggle_q   <= 1'b0;
            busrq_n_q  <= 1'b1;
            hs_grant_q <= 1'b0;
            paused_q   <= 1'b0;
            dim_q      <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= btn_prev_d;
            vbl_prev_q <= vbl_prev_d;
            toggle_q   <= toggle_d;
            busrq_n_q  <= busrq_n_d;
            hs_grant_q <= hs_grant_d;
            paused_q   <= paused_d;
            dim_q      <= dim_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign bus.O_CPU_BUSRQ_n = busrq_n_q;
    assign bus.O_HS_GRANT    = hs_grant_q;
    assign bus.O_PAUSED      = paused_q;
    assign bus.O_DIM         = dim_q;
    assign bus.O_ACK_ERR     = ack_err_q;

endmodule

// File: tb/tb_mario_pause_ctrl.sv
// Self-checking bench for mario_pause_ctrl (DIM_CYCLES=100, ACK_TIMEOUT=16).
// A small Z80 model answers BUSRQ_n on BUSAK_n three cycles later.
// Expected latencies are queued when stimulus is applied and compared when
// the awaited output change is observed.
module tb_mario_pause_ctrl;
    import mario_pkg::*;

    localparam int SEL_BUSRQ  = 0;
    localparam int SEL_PAUSED = 1;
    localparam int SEL_GRANT  = 2;
    localparam int SEL_DIM    = 3;
    localparam int SEL_ERR    = 4;
    localparam int SEL_BUSAK  = 5;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cpu_hist;
    logic       cpu_ack_en;
    logic       rq_low_seen;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n;
    exp_t       sb_q[$];

    mario_pause_ctrl_if bus();

    mario_pause_ctrl #(.DIM_CYCLES(32'd100), .ACK_TIMEOUT(16'd16)) dut (
        .I_CLK_48M (clk),
        .I_RESETn  (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Z80 model: BUSAK_n follows BUSRQ_n three cycles later; can be disabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cpu_hist <= 3'b111;
        else        cpu_hist <= {cpu_hist[1:0], bus.O_CPU_BUSRQ_n};
    end
    assign bus.I_CPU_BUSAK_n = cpu_ack_en ? cpu_hist[2] : 1'b1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input int obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    function automatic int get_sig(input int sel);
        case (sel)
            SEL_BUSRQ:  return int'(bus.O_CPU_BUSRQ_n);
            SEL_PAUSED: return int'(bus.O_PAUSED);
            SEL_GRANT:  return int'(bus.O_HS_GRANT);
            SEL_DIM:    return int'(bus.O_DIM);
            SEL_ERR:    return int'(bus.O_ACK_ERR);
            SEL_BUSAK:  return int'(bus.I_CPU_BUSAK_n);
            default:    return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.O_CPU_BUSRQ_n == 1'b0) rq_low_seen = 1'b1;
    endtask

    task automatic tick_n(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Cycles until the selected signal equals val; -1 if the budget expires.
    task automatic wait_sig(input int sel, input int val, input int max_cyc, output int cnt);
        cnt = 0;
        while ((get_sig(sel) != val) && (cnt < max_cyc)) begin
            tick();
            cnt++;
        end
        if (get_sig(sel) != val) cnt = -1;
    endtask

    task automatic pulse_btn();
        bus.I_PAUSE_BTN = 1'b1;
        tick();
        bus.I_PAUSE_BTN = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_busrq_n"}, int'(bus.O_CPU_BUSRQ_n), 1);
        check_eq({pfx, "_grant"},   int'(bus.O_HS_GRANT), 0);
        check_eq({pfx, "_paused"},  int'(bus.O_PAUSED), 0);
        check_eq({pfx, "_dim"},     int'(bus.O_DIM), 0);
        check_eq({pfx, "_ack_err"}, int'(bus.O_ACK_ERR), 0);
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst_n              = 1'b0;
        bus.I_PAUSE_BTN    = 1'b0;
        bus.I_OSD_OPEN     = 1'b0;
        bus.I_OSD_PAUSE_EN = 1'b0;
        bus.I_HS_REQ       = 1'b0;
        bus.I_VBLANK       = 1'b0;
        cpu_ack_en         = 1'b1;
        rq_low_seen        = 1'b0;
        #12;
        check_reset_outputs("reset");
        tick_n(2);
        rst_n = 1'b1;
        tick_n(3);

        // 1: button mid-frame, halt on the next VBLANK rise.
        pulse_btn();
        tick_n(6);
        check_eq("t1_sync_busrq_n", int'(bus.O_CPU_BUSRQ_n), 1);
        check_eq("t1_sync_state", int'(dut.state_q), int'(SYNC));
        bus.I_VBLANK = 1'b1;
        sb_push("t1_busrq_fall_lat", 1);
        wait_sig(SEL_BUSRQ, 0, 8, n);
        sb_pop_check(n);
        sb_push("t1_paused_lat", 4);
        wait_sig(SEL_PAUSED, 1, 8, n);
        sb_pop_check(n);
        bus.I_VBLANK = 1'b0;
        check_eq("t1_grant_idle", int'(bus.O_HS_GRANT), 0);

        // 2: dim after exactly 100 paused cycles, cleared on leaving PAUSED.
        sb_push("t2_dim_lat", 100);
        wait_sig(SEL_DIM, 1, 200, n);
        sb_pop_check(n);
        tick_n(50);
        check_eq("t2_dim_held", int'(bus.O_DIM), 1);
        pulse_btn();
        sb_push("t2_release_lat", 1);
        wait_sig(SEL_BUSRQ, 1, 8, n);
        sb_pop_check(n);
        check_eq("t2_dim_cleared", int'(bus.O_DIM), 0);
        check_eq("t2_paused_cleared", int'(bus.O_PAUSED), 0);
        tick_n(6);
        check_eq("t2_back_to_run", int'(dut.state_q), int'(RUN));

        // 3: hiscore-only pause, grant latency, no dimming.
        bus.I_HS_REQ = 1'b1;
        tick_n(4);
        bus.I_VBLANK = 1'b1;
        wait_sig(SEL_BUSAK, 0, 12, n);
        check_eq("t3_busak_seen", int'(n >= 0), 1);
        sb_push("t3_grant_lat", 2);
        wait_sig(SEL_GRANT, 1, 8, n);
        sb_pop_check(n);
        bus.I_VBLANK = 1'b0;
        check_eq("t3_paused", int'(bus.O_PAUSED), 1);
        tick_n(120);
        check_eq("t3_no_dim", int'(bus.O_DIM), 0);
        check_eq("t3_grant_held", int'(bus.O_HS_GRANT), 1);
        bus.I_HS_REQ = 1'b0;
        sb_push("t3_grant_drop_lat", 1);
        wait_sig(SEL_GRANT, 0, 4, n);
        sb_pop_check(n);
        check_eq("t3_release_busrq_n", int'(bus.O_CPU_BUSRQ_n), 1);
        tick_n(6);

        // 4: CPU never acknowledges, forced pause and sticky error.
        check_eq("t4_err_before", int'(bus.O_ACK_ERR), 0);
        cpu_ack_en = 1'b0;
        pulse_btn();
        tick_n(4);
        bus.I_VBLANK = 1'b1;
        sb_push("t4_busrq_fall_lat", 1);
        wait_sig(SEL_BUSRQ, 0, 8, n);
        sb_pop_check(n);
        sb_push("t4_timeout_lat", 16);
        wait_sig(SEL_PAUSED, 1, 40, n);
        sb_pop_check(n);
        bus.I_VBLANK = 1'b0;
        check_eq("t4_ack_err", int'(bus.O_ACK_ERR), 1);
        pulse_btn();
        wait_sig(SEL_BUSRQ, 1, 8, n);
        check_eq("t4_unpaused", int'(n >= 0), 1);
        tick_n(6);
        check_eq("t4_err_sticky", int'(bus.O_ACK_ERR), 1);
        cpu_ack_en = 1'b1;
        tick_n(2);
        check_eq("t4_run", int'(dut.state_q), int'(RUN));

        // 5: OSD pause withdrawn before VBLANK never requests the bus.
        rq_low_seen        = 1'b0;
        bus.I_OSD_PAUSE_EN = 1'b1;
        bus.I_OSD_OPEN     = 1'b1;
        tick_n(3);
        check_eq("t5_sync", int'(dut.state_q), int'(SYNC));
        bus.I_OSD_OPEN = 1'b0;
        tick_n(3);
        bus.I_VBLANK = 1'b1;
        tick_n(4);
        bus.I_VBLANK = 1'b0;
        tick_n(2);
        check_eq("t5_busrq_never_low", int'(rq_low_seen), 0);
        check_eq("t5_run", int'(dut.state_q), int'(RUN));

        // 6: button and hiscore together, one halt; then reset while granted.
        bus.I_PAUSE_BTN = 1'b1;
        bus.I_HS_REQ    = 1'b1;
        tick();
        bus.I_PAUSE_BTN = 1'b0;
        tick_n(3);
        bus.I_VBLANK = 1'b1;
        sb_push("t6_busrq_fall_lat", 1);
        wait_sig(SEL_BUSRQ, 0, 8, n);
        sb_pop_check(n);
        bus.I_VBLANK = 1'b0;
        sb_push("t6_grant_lat", 5);
        wait_sig(SEL_GRANT, 1, 12, n);
        sb_pop_check(n);
        bus.I_HS_REQ = 1'b0;
        sb_push("t6_grant_drop_lat", 1);
        wait_sig(SEL_GRANT, 0, 4, n);
        sb_pop_check(n);
        tick_n(3);
        check_eq("t6_toggle_holds_pause", int'(bus.O_PAUSED), 1);
        bus.I_HS_REQ = 1'b1;
        sb_push("t6_regrant_lat", 1);
        wait_sig(SEL_GRANT, 1, 4, n);
        sb_pop_check(n);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async_reset");
        #4;
        rst_n = 1'b1;
        tick_n(2);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
